// File: rtl/fpmul_param_if.sv
// Handshake and data bundle for the iterative floating-point multiplier.
// The requester uses the master modport; the multiplier uses the slave modport.
interface fpmul_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] p;
    logic         nan;
    logic         inf;
    logic         zero;
    logic         uf;
    logic         of;

    modport master (
        output start, a, b,
        input  busy, done, p, nan, inf, zero, uf, of
    );

    modport slave (
        input  start, a, b,
        output busy, done, p, nan, inf, zero, uf, of
    );
endinterface

// File: rtl/fpmul_param.sv
// Multi-cycle IEEE-754 style multiplier: shift-add mantissa product, flush-to-zero.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fpmul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    fpmul_param_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(MW + 1);
    localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, MUL, NORM, ROUND, CHECK, PACK, DONE
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]         op_reg [2];
    logic                 sign_reg;
    logic signed [XW-1:0] exp_reg;
    logic [PW-1:0]        mcand_reg;
    logic [MW-1:0]        mplier_reg;
    logic [PW-1:0]        prod_reg;
    logic [CW-1:0]        cnt_reg;
    logic [MAN_W-1:0]     man_reg;
    logic [W-1:0]         res_p_reg;
    logic [4:0]           res_flags_reg;   // {nan, inf, zero, uf, of}
    logic [W-1:0]         p_reg;
    logic [4:0]           flags_reg;

    logic [1:0]           is_zero, is_inf, is_nan;
    logic [EXP_W-1:0]     exp_f [2];
    logic [MAN_W-1:0]     man_f [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            assign exp_f[gi]   = op_reg[gi][W-2 -: EXP_W];
            assign man_f[gi]   = op_reg[gi][MAN_W-1:0];
            // Subnormals are flushed, so any zero exponent counts as zero.
            assign is_zero[gi] = (exp_f[gi] == '0);
            assign is_inf[gi]  = (&exp_f[gi]) && (man_f[gi] == '0);
            assign is_nan[gi]  = (&exp_f[gi]) && (man_f[gi] != '0);
        end
    endgenerate

    logic special, nan_case, sign_x;
    assign nan_case = (|is_nan) || (is_inf[0] && is_zero[1]) || (is_zero[0] && is_inf[1]);
    assign special  = (|is_nan) || (|is_inf) || (|is_zero);
    assign sign_x   = op_reg[0][W-1] ^ op_reg[1][W-1];

    // After NORM the hidden one sits in the top product bit.
    logic [MAN_W-1:0] man_trunc;
    assign man_trunc = prod_reg[PW-2 -: MAN_W];
`ifdef FPMUL_RNE_EN
    logic guard, sticky, round_up;
    assign guard    = prod_reg[MAN_W];
    assign sticky   = |prod_reg[MAN_W-1:0];
    assign round_up = guard && (sticky || man_trunc[0]);
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = CLASSIFY;
            end
            CLASSIFY: state_next = special ? PACK : MUL;
            MUL:      if (cnt_reg == CW'(MAN_W)) state_next = NORM;
            NORM:     state_next = ROUND;
            ROUND:    state_next = CHECK;
            CHECK:    state_next = PACK;
            PACK:     state_next = DONE;
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg[0]     <= '0;
            op_reg[1]     <= '0;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prod_reg      <= '0;
            cnt_reg       <= '0;
            man_reg       <= '0;
            res_p_reg     <= '0;
            res_flags_reg <= '0;
            p_reg         <= '0;
            flags_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg[0] <= bus.a;
                        op_reg[1] <= bus.b;
                        p_reg     <= '0;
                        flags_reg <= '0;
                    end
                end
                CLASSIFY: begin
                    sign_reg      <= sign_x;
                    exp_reg       <= XW'(exp_f[0]) + XW'(exp_f[1]) - BIAS;
                    mcand_reg     <= PW'({1'b1, man_f[0]});
                    mplier_reg    <= {1'b1, man_f[1]};
                    prod_reg      <= '0;
                    cnt_reg       <= '0;
                    res_p_reg     <= '0;
                    res_flags_reg <= '0;
                    if (nan_case) begin
                        res_p_reg     <= {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                        res_flags_reg <= 5'b10000;
                    end else if (|is_inf) begin
                        res_p_reg     <= {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        res_flags_reg <= 5'b01000;
                    end else if (|is_zero) begin
                        res_p_reg     <= {sign_x, {(W-1){1'b0}}};
                        res_flags_reg <= 5'b00100;
                    end
                end
                MUL: begin
                    if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                end
                NORM: begin
                    cnt_reg <= '0;
                    if (prod_reg[PW-1]) exp_reg  <= exp_reg + 1'b1;
                    else                prod_reg <= prod_reg << 1;
                end
                ROUND: begin
`ifdef FPMUL_RNE_EN
                    if (round_up) begin
                        if (&man_trunc) begin
                            man_reg <= '0;
                            exp_reg <= exp_reg + 1'b1;
                        end else begin
                            man_reg <= man_trunc + 1'b1;
                        end
                    end else begin
                        man_reg <= man_trunc;
                    end
`else
                    man_reg <= man_trunc;
`endif
                end
                CHECK: begin
                    if (!exp_reg[XW-1] && (exp_reg >= EXP_MAX)) begin
                        res_p_reg     <= {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        res_flags_reg <= 5'b01001;
                    end else if (exp_reg[XW-1] || (exp_reg == '0)) begin
                        res_p_reg     <= {sign_reg, {(W-1){1'b0}}};
                        res_flags_reg <= 5'b00110;
                    end else begin
                        res_p_reg     <= {sign_reg, exp_reg[EXP_W-1:0], man_reg};
                        res_flags_reg <= 5'b00000;
                    end
                end
                PACK: begin
                    p_reg     <= res_p_reg;
                    flags_reg <= res_flags_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.p = p_reg;
    assign {bus.nan, bus.inf, bus.zero, bus.uf, bus.of} = flags_reg;
endmodule

// File: tb/tb_fpmul_param.sv
// Randomized self-checking bench for fpmul_param at single-precision sizes,
// compared against an arithmetic reference model of the multiply rules.
module tb_fpmul_param;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fpmul_param_if #(.EXP_W(8), .MAN_W(23)) dut_if ();

    fpmul_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {dut_if.nan, dut_if.inf, dut_if.zero, dut_if.uf, dut_if.of};
    endfunction

    // Reference: classify, exact 48-bit product, normalize, optional RNE, range check.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic [4:0] fl, output int lat);
        int          ea, eb, e;
        logic [47:0] prod;
        logic [23:0] mant;
        bit          sg, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sg = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        lat = 2;
        fl  = 5'b0;
        p   = 32'h0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            p = 32'h7FFFFFFF; fl = 5'b10000;
        end else if (ia || ib) begin
            p = {sg, 8'hFF, 23'h0}; fl = 5'b01000;
        end else if (za || zb) begin
            p = {sg, 31'h0}; fl = 5'b00100;
        end else begin
            lat  = 29;
            e    = ea + eb - 127;
            prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            if (prod >= 48'h8000_0000_0000) e = e + 1;
            else                            prod = prod * 2;
            mant = 24'((prod >> 24) & 48'h7FFFFF);
`ifdef FPMUL_RNE_EN
            if (((prod >> 23) & 48'h1) != 0 &&
                (((prod & 48'h7FFFFF) != 0) || mant[0])) mant = mant + 1;
            if (mant == 24'h800000) begin
                mant = 0;
                e    = e + 1;
            end
`endif
            if (e >= 255) begin
                p = {sg, 8'hFF, 23'h0}; fl = 5'b01001;
            end else if (e <= 0) begin
                p = {sg, 31'h0}; fl = 5'b00110;
            end else begin
                p = {sg, e[7:0], mant[22:0]};
            end
        end
    endfunction

    // Issues one operation from IDLE and checks capture, latency, result and flags.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string tag);
        logic [31:0] ep;
        logic [4:0]  ef;
        int          el, lat;
        bit          got;
        model(av, bv, ep, ef, el);
        dut_if.a     = av;
        dut_if.b     = bv;
        dut_if.start = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        dut_if.a     = $urandom;
        dut_if.b     = $urandom;
        check({tag, "_acc"}, 64'(dut_if.busy), 64'd1);
        check({tag, "_clr"}, {27'h0, flags_now(), dut_if.p}, 64'h0);
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (dut_if.done) got = 1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_p"},   64'(dut_if.p), 64'(ep));
        check({tag, "_fl"},  64'(flags_now()), 64'(ef));
        $display("op %s a=%08h b=%08h p=%08h flags=%05b lat=%0d", tag, av, bv, dut_if.p, flags_now(), lat);
        @(posedge clk); #1;
        check({tag, "_end"}, {62'h0, dut_if.done, dut_if.busy}, 64'h0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        sel = $urandom_range(0, 11);
        m   = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; m = 23'h0; end
            2:       begin e = 8'hFF; m = m | 23'h1; end
            3, 4:    e = 8'($urandom_range(190, 254));
            5, 6:    e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    initial begin
        int          first_done, n_done, last_done;
        logic [31:0] ep;
        logic [4:0]  ef;
        int          el, wait_cnt;

        rst          = 1'b0;
        dut_if.start = 1'b0;
        dut_if.a     = '0;
        dut_if.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {27'h0, flags_now(), dut_if.p}, 64'h0);
        check("rst_ctl", {62'h0, dut_if.done, dut_if.busy}, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(32'h3FC00000, 32'h40000000, "mul_1p5x2");
        run_op(32'h7F800000, 32'h00000000, "inf_x_zero");
        run_op(32'h7F000000, 32'h7F000000, "overflow");
        run_op(32'h00800000, 32'h00800000, "underflow");
        run_op(32'h3FC00001, 32'h3FC00001, "round");
        check("round_val", 64'(dut_if.p),
`ifdef FPMUL_RNE_EN
              64'h40100002);
`else
              64'h40100001);
`endif
        run_op(32'hFF800000, 32'h3F800000, "neg_inf");
        run_op(32'h80000000, 32'h40000000, "neg_zero");
        run_op(32'h3FFFFFFF, 32'h3FFFFFFF, "carry");

        // Reset ten cycles into MUL, with start asserted during reset.
        dut_if.a     = 32'h40490FDB;
        dut_if.b     = 32'h402DF854;
        dut_if.start = 1'b1;
        @(posedge clk); #1;
        dut_if.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_mul_busy", 64'(dut_if.busy), 64'd1);
        rst          = 1'b0;
        dut_if.start = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ctl", {62'h0, dut_if.done, dut_if.busy}, 64'h0);
        check("mid_rst_out", {27'h0, flags_now(), dut_if.p}, 64'h0);
        @(posedge clk); #1;
        check("rst_dom_start", 64'(dut_if.busy), 64'd0);
        rst = 1'b1;
        run_op(32'hC0000000, 32'h3F800000, "after_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(rand_op(), rand_op(), $sformatf("rnd%0d", i));
        end

        // Start held high across two operations.
        dut_if.a     = 32'h3FC00000;
        dut_if.b     = 32'h40000000;
        dut_if.start = 1'b1;
        model(dut_if.a, dut_if.b, ep, ef, el);
        @(posedge clk); #1;
        first_done = -1;
        last_done  = -10;
        n_done     = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (i == last_done + 1) check("held_idle", 64'(dut_if.busy), 64'd0);
            if (i == last_done + 2) check("held_reacc", 64'(dut_if.busy), 64'd1);
            if (dut_if.done) begin
                n_done++;
                last_done = i;
                if (first_done < 0) begin
                    first_done = i;
                    check("held_p", 64'(dut_if.p), 64'(ep));
                end
            end
        end
        check("held_first_lat", 64'(first_done), 64'(el));
        check("held_dones", 64'(n_done), 64'd2);
        dut_if.start = 1'b0;
        wait_cnt = 0;
        while (!dut_if.done && wait_cnt < 60) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("held_drain", 64'(dut_if.done), 64'd1);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpmul_param.md
FPMUL_PARAM -- requirements
Module: fpmul_param

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter MAN_W, default 23: stored mantissa field width; operand/product width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a, b  input  W  operands {sign, exponent, mantissa}, IEEE-754 layout, bias 2^(EXP_W-1)-1.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; p and flags valid.
REQ-009 p  output  W  product.
REQ-010 nan, inf, zero, uf, of  output  1 each  result class / underflow / overflow flags.

Function
REQ-011 FSM states: IDLE, CLASSIFY, MUL, NORM, ROUND, CHECK, PACK, DONE.
REQ-012 IDLE with start=1: a, b captured into internal registers, go to CLASSIFY; start=0: stay.
REQ-013 start outside IDLE ignored; a/b changes after capture have no effect.
REQ-014 CLASSIFY: exponent 0 (incl. subnormal, flush-to-zero) = zero; all-ones exp, mantissa 0 = inf; all-ones exp, mantissa nonzero = NaN.
REQ-015 Special priority: NaN operand or inf*zero -> nan=1, p={0, all-ones exp, all-ones mantissa}; else inf operand -> inf=1, p={sa^sb, all-ones, 0}; else zero operand -> zero=1, p={sa^sb, 0, 0}; special goes CLASSIFY->PACK.
REQ-016 Normal: sign sa^sb; exponent ea+eb-bias computed signed in EXP_W+2 bits; CLASSIFY->MUL.
REQ-017 MUL: iterative shift-add of hidden-bit mantissas (MAN_W+1 bits), one multiplier bit per cycle, bit counter, exactly MAN_W+1 cycles, 2*(MAN_W+1)-bit product.
REQ-018 NORM: product bit 2*MAN_W+1 set -> exponent+1, keep; else shift product left 1.
REQ-019 ROUND: per REQ-027; mantissa all-ones round-up carry -> mantissa 0 (hidden 1), exponent+1.
REQ-020 CHECK: exponent >= 2^EXP_W-1 -> of=1, inf=1, p={sign, all-ones, 0}; exponent <= 0 -> uf=1, zero=1, p={sign, 0, 0}; else no flag.
REQ-021 PACK: p and flags registered; DONE: done=1 one cycle, then IDLE.
REQ-022 Latency, start sampled at edge E0: normal -> done high after edge E0+MAN_W+6 (29 cycles at defaults); special -> after E0+2.
REQ-023 p and flags hold from DONE until next accepted start, then clear to 0 in CLASSIFY.
REQ-024 Back-to-back: next start accepted in IDLE cycle after DONE; no start lost in IDLE.

Reset
REQ-025 rst=0 at any edge, any state incl. mid-MUL: state IDLE, busy=0, done=0, p=0, all flags 0, counter 0, internal registers 0.
REQ-026 rst=0 dominates start in same cycle; first start accepted on first edge with rst=1.

Configuration
REQ-027 FPMUL_RNE_EN defined: round-to-nearest-even, guard G, sticky S=OR of lower bits, increment if G&(S|LSB); undefined: truncate, no ROUND increment, ROUND still one cycle so latency unchanged.

Verification (EXP_W=8, MAN_W=23)
REQ-028 a=0x3FC00000, b=0x40000000 -> p=0x40400000, all flags 0, done 29 cycles after start.
REQ-029 a=0x7F800000, b=0x00000000 -> nan=1, p=0x7FFFFFFF, done 2 cycles after start.
REQ-030 a=0x7F000000, b=0x7F000000 -> of=1, inf=1, p=0x7F800000; a=0x00800000, b=0x00800000 -> uf=1, zero=1, p=0x00000000.
REQ-031 a=b=0x3FC00001 -> p=0x40100002 with FPMUL_RNE_EN, 0x40100001 without.
REQ-032 rst low 10 cycles into MUL -> next cycle busy=0, done=0, p=0; following start a=0xC0000000, b=0x3F800000 -> p=0xC0000000.
REQ-033 start held high through whole operation -> exactly one done per IDLE acceptance, second op begins cycle after DONE.
